// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants used by the bus slaves.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

endpackage

// File: rtl/ahb_lane_dec.sv
// Byte-lane strobe and alignment decode for a 32-bit AHB data bus.
module ahb_lane_dec (
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       illegal
);
  import ahb_pkg::*;

  always_comb begin
    strb    = 4'b0000;
    illegal = 1'b0;
    case (size)
      BYTE: strb = 4'b0001 << addr;
      HALF: begin
        strb    = addr[1] ? 4'b1100 : 4'b0011;
        illegal = addr[0];
      end
      WORD: begin
        strb    = 4'b1111;
        illegal = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Illegal transfers must never strobe a lane.
    if (illegal) strb = 4'b0000;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM array with two-cycle ERROR.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per legal transfer.
module ahb_sram_slave #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  import ahb_pkg::*;

  localparam int DEPTH = 1 << (ADDR_W - 2);

  slv_state_e          state_q, state_d;
  logic                write_q;
  logic [ADDR_W-3:0]   addr_q;
  logic [3:0]          strb_q;
  logic [3:0]          strb;
  logic                illegal;
  logic                accept;
  logic                cap;
  logic [31:0]         mem [DEPTH];

`ifdef AHB_SLV_WAIT_EN
  logic [3:0]          wcnt_q, wcnt_d;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HADDR[31:ADDR_W]};

  assign accept = HSEL & HREADY & HTRANS[1];

  ahb_lane_dec u_lane_dec (
    .size    (HSIZE),
    .addr    (HADDR[1:0]),
    .strb    (strb),
    .illegal (illegal)
  );

  always_comb begin
    state_d   = state_q;
    cap       = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;
`ifdef AHB_SLV_WAIT_EN
    wcnt_d    = wcnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
        if (state_q == ST_DATA && !write_q) HRDATA = mem[addr_q];
        // Any state that ends with HREADYOUT=1 may take the next address phase.
        state_d = ST_IDLE;
        if (accept) begin
          cap = 1'b1;
          if (illegal) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DATA;
`ifdef AHB_SLV_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              state_d = ST_WAIT;
              wcnt_d  = 4'(WAIT_CYCLES - 1);
            end
`endif
          end
        end
      end
`ifdef AHB_SLV_WAIT_EN
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wcnt_q == 4'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
`endif
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      wcnt_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef AHB_SLV_WAIT_EN
      wcnt_q  <= wcnt_d;
`endif
      if (cap) write_q <= HWRITE & ~illegal;
    end
  end

  always_ff @(posedge HCLK) begin
    if (cap) begin
      addr_q <= HADDR[ADDR_W-1:2];
      strb_q <= strb;
    end
  end

  // A reset-forced IDLE state blocks the commit of any in-flight write.
  always_ff @(posedge HCLK) begin
    if (state_q == ST_DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave that terminates the bus signals carried by the shared `AHB` interface bundle and backs them with an on-chip word-organised SRAM array. It consumes master-side address/control/write-data signals and produces `HREADYOUT`, `HRESP` and `HRDATA`. It supports byte, halfword and word transfers, optional wait-state insertion and a two-cycle ERROR response for illegal transfers. It is the first real slave behind the bus bundle and the default target for directed AHB tests.

## Interface
Parameters:
- `ADDR_W`, 12, byte-address width of the array; depth = 2^(ADDR_W-2) 32-bit words; upper `HADDR` bits ignored.
- `WAIT_CYCLES`, 1, wait states inserted per data phase when `AHB_SLV_WAIT_EN` is defined; legal range 0..15.

Ports:
- `HCLK` in 1: single clock, all logic rising-edge.
- `HRESET` in 1: asynchronous, active-low reset.
- `HSEL` in 1: slave select, from decoder bit 0.
- `HADDR` in 32: transfer address.
- `HTRANS` in 2: IDLE/BUSY/NONSEQ/SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: 0 = byte, 1 = halfword, 2 = word; others illegal.
- `HBURST` in 3, `HPROT` in 4: accepted, functionally ignored.
- `HWDATA` in 32: write data, valid in data phase.
- `HREADY` in 1: bus-level ready (mux output).
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` out 32: read data.

## Operation
- Address phase accepted when `HSEL & HREADY & HTRANS[1]`. Captures `HADDR[ADDR_W-1:0]`, `HWRITE`, `HSIZE` into registers.
- IDLE or BUSY with `HSEL & HREADY`: no access; next cycle is a zero-wait OKAY.
- Legality check at acceptance: `HSIZE > 2`, halfword with `HADDR[0]=1`, or word with `HADDR[1:0]!=0` → transfer marked illegal.
- FSM states:
  - `IDLE`: `HREADYOUT=1`, `HRESP=0`. Legal accept → `WAIT` if the wait count > 0, else `DATA`. Illegal accept → `ERR1`.
  - `WAIT`: `HREADYOUT=0`; counter decrements; at 0 → `DATA`.
  - `DATA`: `HREADYOUT=1`. A write commits at the end of this cycle. A new accept in the same cycle follows the `IDLE` rules; otherwise → `IDLE`.
  - `ERR1`: `HREADYOUT=0`, `HRESP=1` → `ERR2`.
  - `ERR2`: `HREADYOUT=1`, `HRESP=1`. New accept follows the `IDLE` rules.
- Write byte strobes come from registered size and `addr[1:0]`:
  - byte: lane `addr[1:0]`.
  - halfword: lanes {1,0} or {3,2}.
  - word: all lanes.
  - Only strobed lanes of `mem[addr[ADDR_W-1:2]]` update, taking the same lanes of `HWDATA`.
- Read: `HRDATA` = full word `mem[addr]` while in `DATA` for a read, else 32'h0. The word is not lane-shifted; the master extracts the lanes.
- Illegal transfers never write the array. `HRDATA` = 0 during `ERR1` and `ERR2`.
- Master abandoning the transfer after `ERR1` (IDLE in the `ERR2` address phase): honoured, → `IDLE`.

## Timing
- Reset values: `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, state `IDLE`, wait counter 0. Array contents are not reset.
- Latency, zero wait: data phase completes in the cycle after the address phase. With N waits it completes N+1 cycles after.
- Back-to-back: a read at address A immediately after a write to A returns the new data. The write commits at the clock edge that starts the read's data phase.
- Reset mid-transfer: an in-flight write is discarded and outputs return to their reset values asynchronously.

## Configuration
- Macro `AHB_SLV_WAIT_EN`:
  - Defined: every legal transfer takes `WAIT_CYCLES` wait states.
  - Undefined: the `WAIT` state and counter are compiled out, all legal transfers are zero-wait, and `WAIT_CYCLES` is ignored.
  - ERROR behaviour is identical in both builds.

## Structure
- Shared package `ahb_pkg` holds:
  - `htrans_e` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - `hsize_e` (BYTE=0, HALF=1, WORD=2).
  - `HRESP_OKAY` and `HRESP_ERROR` constants.
  - The slave FSM state enum.
- One combinational sub-module, `ahb_lane_dec`: inputs `size` and `addr[1:0]`; outputs a 4-bit byte strobe and an `illegal` flag. It is reused by future slaves.

## Test plan
- Reset asserted, then released → `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`.
- Word write 32'hDEADBEEF to 0x010, then word read 0x010 → `HRDATA=32'hDEADBEEF`, `HRESP=0` throughout.
- Byte write 8'hAA (on lane 2) to 0x012 over word 32'h11223344 at 0x010 → read returns 32'h11AA3344.
- Halfword write to 0x001 → `ERR1` cycle (`HREADYOUT=0`, `HRESP=1`), then `ERR2` (`HREADYOUT=1`, `HRESP=1`); the word at 0x000 is unchanged.
- With `AHB_SLV_WAIT_EN`, `WAIT_CYCLES=3`, word read → `HREADYOUT` low exactly 3 cycles, data on the 4th. Without the macro → 0 wait cycles.
- Back-to-back NONSEQ write 0x020 = 32'h5, then read 0x020 → read returns 32'h5. `HRESET` pulsed during a write's wait state → no array update.
